memory_subsystem: RTL and testbench

- Downstream of the CPU control unit; consumes its MARin, MDRin, Read and Write strobes.
- Holds MAR and MDR and owns the main word-addressed RAM.
- Sequences multi-cycle read and write operations with a busy/done handshake, so the fetch, ld and st states have a fixed, verifiable memory timing.

---
 rtl/memory_subsystem.sv | 128 ++++++++++++
 tb/tb_memory_subsystem.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/memory_subsystem.sv
// MAR/MDR holding registers and word-addressed RAM with a busy/done handshake.
// Read/Write strobes launch one fixed-latency access; a held strobe never retriggers.
module memory_subsystem #(
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 32,
  parameter int READ_LAT  = 2,
  parameter int WRITE_LAT = 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [DATA_W-1:0] BusMuxOut,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              Read,
  input  logic              Write,
  output logic [DATA_W-1:0] MDR_data,
  output logic [ADDR_W-1:0] MAR_addr,
  output logic              Mem_busy,
  output logic              Mem_done,
  output logic              Mem_err
);

  // state   | meaning
  // IDLE    | waiting for a single Read or Write strobe
  // RD_WAIT | read in flight, counter running down to the MDR update
  // WR_WAIT | write in flight, counter running down to the RAM update
  // HOLD    | access done, waiting for both strobes to drop
  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, HOLD} state_t;

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [3:0] RD_CNT = 4'(READ_LAT);
  localparam logic [3:0] WR_CNT = 4'(WRITE_LAT);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [ADDR_W-1:0] op_addr_q, op_addr_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic [DATA_W-1:0] op_data_q, op_data_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              ram_we;

  logic [DATA_W-1:0] ram [DEPTH];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_addr_d = op_addr_q;
    op_data_d = op_data_q;
    mar_d     = MARin ? BusMuxOut[ADDR_W-1:0] : mar_q;
    mdr_d     = MDRin ? BusMuxOut : mdr_q;
    done_d    = 1'b0;
    err_d     = err_q;
    ram_we    = 1'b0;
    case (state_q)
      IDLE: begin
        if (Read && Write) begin
          err_d = 1'b1;
        end else if (Read) begin
          op_addr_d = mar_q;
          cnt_d     = RD_CNT;
          state_d   = RD_WAIT;
        end else if (Write) begin
          op_addr_d = mar_q;
          op_data_d = mdr_q;
          cnt_d     = WR_CNT;
          state_d   = WR_WAIT;
        end
      end
      RD_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        // Completion edge: read data overrides a simultaneous MDRin load.
        if (cnt_q == 4'd1) begin
          mdr_d   = ram[op_addr_q];
          done_d  = 1'b1;
          state_d = Read ? HOLD : IDLE;
        end
      end
      WR_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          ram_we  = 1'b1;
          done_d  = 1'b1;
          state_d = Write ? HOLD : IDLE;
        end
      end
      HOLD: begin
        if (!Read && !Write) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mar_q     <= '0;
      mdr_q     <= '0;
      op_addr_q <= '0;
      op_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mar_q     <= mar_d;
      mdr_q     <= mdr_d;
      op_addr_q <= op_addr_d;
      op_data_q <= op_data_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // RAM has no reset; a reset forces IDLE, so an aborted write never commits.
  always_ff @(posedge Clock) begin
    if (ram_we) ram[op_addr_q] <= op_data_q;
  end

  assign MDR_data = mdr_q;
  assign MAR_addr = mar_q;
  assign Mem_busy = (state_q == RD_WAIT) || (state_q == WR_WAIT);
  assign Mem_done = done_q;
  assign Mem_err  = err_q;

endmodule

// File: tb/tb_memory_subsystem.sv
// Scoreboarded bench for memory_subsystem; a second instance with WRITE_LAT=3
// shares the stimulus and is used for the write-abort case.
module tb_memory_subsystem;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [31:0] BusMuxOut;
  logic        MARin, MDRin, Read, Write;

  logic [31:0] mdr0, mdr1;
  logic [8:0]  mar0, mar1;
  logic        busy0, done0, err0, busy1, done1, err1;

  typedef struct {bit is_rd; logic [31:0] data;} exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;

  memory_subsystem u_dut (
    .Clock(Clock), .Reset(Reset), .BusMuxOut(BusMuxOut), .MARin(MARin), .MDRin(MDRin),
    .Read(Read), .Write(Write), .MDR_data(mdr0), .MAR_addr(mar0),
    .Mem_busy(busy0), .Mem_done(done0), .Mem_err(err0)
  );

  memory_subsystem #(.WRITE_LAT(3)) u_dut3 (
    .Clock(Clock), .Reset(Reset), .BusMuxOut(BusMuxOut), .MARin(MARin), .MDRin(MDRin),
    .Read(Read), .Write(Write), .MDR_data(mdr1), .MAR_addr(mar1),
    .Mem_busy(busy1), .Mem_done(done1), .Mem_err(err1)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  always @(negedge Clock) begin
    if (Reset && done0) begin
      if (sb.size() == 0) begin
        chk("done_unexpected", 32'(done0), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.is_rd) chk("sb_rd_data", mdr0, e.data);
      end
    end
  end

  task automatic load_mar(input logic [31:0] v, input logic [8:0] exp);
    @(negedge Clock);
    BusMuxOut = v; MARin = 1'b1;
    @(negedge Clock);
    MARin = 1'b0;
    chk("mar_load", 32'(mar0), 32'(exp));
  endtask

  task automatic load_mdr(input logic [31:0] v);
    @(negedge Clock);
    BusMuxOut = v; MDRin = 1'b1;
    @(negedge Clock);
    MDRin = 1'b0;
    chk("mdr_load", mdr0, v);
  endtask

  // Strobes are high for 'hold' sampling edges starting at E0; k counts negedges after E0.
  task automatic do_op(input bit rd, input bit wr, input int hold, input int lat,
                       input logic [31:0] pre, input logic [31:0] exp, input bit expect_op);
    int busy_n = 0;
    int done_n = 0;
    @(negedge Clock);
    Read = rd; Write = wr;
    if (expect_op) sb.push_back('{is_rd: rd, data: exp});
    for (int k = 1; k <= hold + lat + 3; k++) begin
      @(negedge Clock);
      if (k == hold) begin Read = 1'b0; Write = 1'b0; end
      busy_n += int'(busy0);
      done_n += int'(done0);
      if (expect_op && k == lat) begin
        chk("done_early", 32'(done0), 32'd0);
        if (rd) chk("mdr_before_lat", mdr0, pre);
      end
      if (expect_op && k == lat + 1) begin
        chk("done_at_lat", 32'(done0), 32'd1);
        if (rd) chk("mdr_at_lat", mdr0, exp);
      end
    end
    chk("busy_cycles", 32'(busy_n), expect_op ? 32'(lat) : 32'd0);
    chk("done_pulses", 32'(done_n), expect_op ? 32'd1 : 32'd0);
  endtask

  initial begin
    Reset = 1'b0; BusMuxOut = '0; MARin = 0; MDRin = 0; Read = 0; Write = 0;
    #1;
    chk("rst_mdr", mdr0, 32'd0);
    chk("rst_mar", 32'(mar0), 32'd0);
    chk("rst_flags", {29'd0, busy0, done0, err0}, 32'd0);
    repeat (2) @(negedge Clock);
    Reset = 1'b1;

    // write then read
    load_mar(32'd5, 9'd5);
    load_mdr(32'hDEADBEEF);
    do_op(0, 1, 3, 1, 32'd0, 32'd0, 1);
    load_mdr(32'd0);
    do_op(1, 0, 2, 2, 32'd0, 32'hDEADBEEF, 1);

    // held strobe: one access only
    load_mdr(32'd0);
    do_op(1, 0, 8, 2, 32'd0, 32'hDEADBEEF, 1);

    // address wrap
    load_mar(32'h205, 9'd5);
    load_mdr(32'h11);
    do_op(0, 1, 1, 1, 32'd0, 32'd0, 1);
    load_mar(32'h005, 9'd5);
    load_mdr(32'd0);
    do_op(1, 0, 1, 2, 32'd0, 32'h11, 1);

    // illegal request
    load_mdr(32'h99);
    do_op(1, 1, 1, 0, 32'd0, 32'd0, 0);
    chk("err_set", 32'(err0), 32'd1);
    do_op(1, 0, 1, 2, 32'h99, 32'h11, 1);
    chk("err_sticky", 32'(err0), 32'd1);

    // abort: RAM[7]=1, then a reset half a cycle into a write of 0xCAFE0000
    load_mar(32'd7, 9'd7);
    load_mdr(32'h1);
    do_op(0, 1, 1, 1, 32'd0, 32'd0, 1);
    load_mdr(32'hCAFE0000);
    @(negedge Clock);
    Write = 1'b1;
    @(negedge Clock);
    chk("abort_busy_before", 32'(busy1), 32'd1);
    Reset = 1'b0;
    #1;
    chk("abort_rst_mdr", mdr1, 32'd0);
    chk("abort_rst_mar", 32'(mar1), 32'd0);
    chk("abort_rst_flags", {29'd0, busy1, done1, err1}, 32'd0);
    chk("abort_rst_flags0", {29'd0, busy0, done0, err0}, 32'd0);
    Write = 1'b0;
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
    load_mar(32'd7, 9'd7);
    load_mdr(32'd0);
    do_op(1, 0, 1, 2, 32'd0, 32'h1, 1);
    chk("abort_rd_lat3", mdr1, 32'h1);
    chk("err_cleared", 32'(err0), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
